// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined datapath: word width, WB control bit
// positions and the MEM-stage access FSM encoding.
// Pure declarations; no logic.
package mips_pkg;
  localparam int WORD_W      = 32;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;
endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with load-enable and bubble insertion.
// Latency 1 (updates on the falling edge of clk).
// Holds its contents while load_i is low; bubble_i or an invalid instruction clears valid and WB controls.
module mem_wb
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic              have_instr_i,
  input  logic [WORD_W-1:0] alu_out_i,
  input  logic [4:0]        reg_dst_i,
  input  logic [1:0]        wb_i,
  input  logic [WORD_W-1:0] read_data_i,
  output logic              have_instr_o,
  output logic [WORD_W-1:0] alu_out_o,
  output logic [4:0]        reg_dst_o,
  output logic [1:0]        wb_o,
  output logic [WORD_W-1:0] read_data_o
);

  // Pipeline register; a squashed or empty slot never carries WB controls.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      have_instr_o <= 1'b0;
      alu_out_o    <= '0;
      reg_dst_o    <= '0;
      wb_o         <= '0;
      read_data_o  <= '0;
    end else if (load_i) begin
      have_instr_o <= have_instr_i & ~bubble_i;
      alu_out_o    <= alu_out_i;
      reg_dst_o    <= reg_dst_i;
      wb_o         <= (bubble_i | ~have_instr_i) ? 2'b00 : wb_i;
      read_data_o  <= read_data_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolve, req/ack data-memory access with timeout, MEM/WB register.
// Latency 1 for non-memory ops, >=2 for loads/stores; state updates on the falling edge.
// stallOut holds upstream while an access is outstanding. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              haveInstrIn,
  input  logic [WORD_W-1:0] pcIn,
  input  logic              zeroIn,
  input  logic [WORD_W-1:0] ALUOutIn,
  input  logic [WORD_W-1:0] readData2In,
  input  logic [4:0]        regFromMuxIn,
  input  logic [1:0]        WBIn,
  input  logic              branchIn,
  input  logic              memReadIn,
  input  logic              memWriteIn,
  input  logic [WORD_W-1:0] dmemRData,
  input  logic              dmemAck,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [WORD_W-1:0] dmemAddr,
  output logic [WORD_W-1:0] dmemWData,
  output logic              pcSrcOut,
  output logic [WORD_W-1:0] branchTargetOut,
  output logic              stallOut,
  output logic              timeoutOut,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalignOut,
`endif
  output logic              haveInstrOut,
  output logic [WORD_W-1:0] readDataOut,
  output logic [WORD_W-1:0] ALUOutOut,
  output logic [4:0]        regFromMuxOut,
  output logic [1:0]        WBOut
);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, to_q, to_d, mis_q, mis_d;
  logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic              acc, misal, stall, wb_load, wb_bubble;
  logic [WORD_W-1:0] wb_rdata;

  assign acc = haveInstrIn & (memReadIn | memWriteIn);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misal       = acc & (ALUOutIn[1:0] != 2'b00);
  assign misalignOut = mis_q;
`else
  assign misal = 1'b0;
`endif

  // Reset forces the combinational stage outputs low as well.
  assign pcSrcOut        = reset & haveInstrIn & branchIn & zeroIn;
  assign branchTargetOut = pcIn;
  assign stallOut        = reset & stall;

  // Next-state, request and MEM/WB load control for the access FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    to_d      = 1'b0;
    mis_d     = 1'b0;
    stall     = 1'b0;
    wb_load   = 1'b1;
    wb_bubble = 1'b0;
    wb_rdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (acc && !misal) begin
          stall     = 1'b1;
          req_d     = 1'b1;
          we_d      = memWriteIn;
          addr_d    = ALUOutIn;
          wdata_d   = readData2In;
          cnt_d     = '0;
          state_d   = ST_WAIT;
          wb_bubble = 1'b1;
        end else if (misal) begin
          mis_d     = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dmemAck) begin
          // Ack beats a coinciding timeout; a write-priority access returns 0.
          stall    = 1'b0;
          req_d    = 1'b0;
          state_d  = ST_IDLE;
          wb_rdata = we_q ? '0 : dmemRData;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          req_d     = 1'b0;
          to_d      = 1'b1;
          wb_bubble = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          wb_load = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, wait counter and registered memory interface.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      to_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      to_q    <= to_d;
      mis_q   <= mis_d;
    end
  end

  assign dmemReq    = req_q;
  assign dmemWe     = we_q;
  assign dmemAddr   = addr_q;
  assign dmemWData  = wdata_q;
  assign timeoutOut = to_q;

  mem_wb u_mem_wb (
    .clk_i        (clk),
    .rst_n_i      (reset),
    .load_i       (wb_load),
    .bubble_i     (wb_bubble),
    .have_instr_i (haveInstrIn),
    .alu_out_i    (ALUOutIn),
    .reg_dst_i    (regFromMuxIn),
    .wb_i         (WBIn),
    .read_data_i  (wb_rdata),
    .have_instr_o (haveInstrOut),
    .alu_out_o    (ALUOutOut),
    .reg_dst_o    (regFromMuxOut),
    .wb_o         (WBOut),
    .read_data_o  (readDataOut)
  );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int MAX_WAIT = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        hv = 0, z = 0, br = 0, mrd = 0, mwr = 0, ack = 0;
  logic [31:0] pc = 0, alu = 0, d2 = 0, rdata = 0;
  logic [4:0]  rf = 0;
  logic [1:0]  wb = 0;
  logic        dmemReq, dmemWe, pcSrcOut, stallOut, timeoutOut, haveInstrOut;
  logic [31:0] dmemAddr, dmemWData, branchTargetOut, readDataOut, ALUOutOut;
  logic [4:0]  regFromMuxOut;
  logic [1:0]  WBOut;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalignOut;
`endif

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(MAX_WAIT), .CNT_W(5)) dut (
    .clk(clk), .reset(rst_n), .haveInstrIn(hv), .pcIn(pc), .zeroIn(z),
    .ALUOutIn(alu), .readData2In(d2), .regFromMuxIn(rf), .WBIn(wb),
    .branchIn(br), .memReadIn(mrd), .memWriteIn(mwr), .dmemRData(rdata),
    .dmemAck(ack), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWData(dmemWData), .pcSrcOut(pcSrcOut), .branchTargetOut(branchTargetOut),
    .stallOut(stallOut), .timeoutOut(timeoutOut),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalignOut(misalignOut),
`endif
    .haveInstrOut(haveInstrOut), .readDataOut(readDataOut), .ALUOutOut(ALUOutOut),
    .regFromMuxOut(regFromMuxOut), .WBOut(WBOut)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An access is a transaction: it is issued, then it either completes on the
  // first ack or is abandoned after MAX_WAIT cycles without one.
  logic        m_busy, e_req, e_we, e_to, e_hv, e_mis;
  int          m_waited;
  logic [31:0] e_addr, e_wdata, e_rd, e_alu;
  logic [4:0]  e_rf;
  logic [1:0]  e_wb;

  function automatic logic misaligned();
`ifdef MEM_MISALIGN_TRAP_EN
    return hv && (mrd || mwr) && (alu[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_access();
    return hv && (mrd || mwr) && !misaligned();
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_waited = 0; e_req = 0; e_we = 0; e_to = 0; e_hv = 0; e_mis = 0;
      e_addr = 0; e_wdata = 0; e_rd = 0; e_alu = 0; e_rf = 0; e_wb = 0;
    end else begin
      e_to = 0; e_mis = 0;
      if (!m_busy) begin
        e_alu = alu; e_rf = rf; e_rd = 0;
        if (is_access()) begin
          m_busy = 1; m_waited = 0;
          e_req = 1; e_we = mwr; e_addr = alu; e_wdata = d2;
          e_hv = 0; e_wb = 0;
        end else begin
          e_mis = misaligned();
          e_hv = hv && !e_mis;
          e_wb = e_hv ? wb : 2'b00;
        end
      end else begin
        m_waited++;
        if (ack) begin
          m_busy = 0; e_req = 0;
          e_hv = hv; e_alu = alu; e_rf = rf; e_wb = hv ? wb : 2'b00;
          e_rd = mwr ? 32'h0 : rdata;
        end else if (m_waited == MAX_WAIT) begin
          m_busy = 0; e_req = 0; e_to = 1; e_hv = 0; e_wb = 0; e_rd = 0;
        end
      end
    end
  end

  // Per-cycle comparison on the rising edge, away from the update edge.
  always @(posedge clk) begin
    logic exp_stall;
    exp_stall = rst_n && (m_busy ? !ack : is_access());
    chk("stallOut", {31'b0, stallOut}, {31'b0, exp_stall});
    chk("pcSrcOut", {31'b0, pcSrcOut}, {31'b0, rst_n && hv && br && z});
    chk("branchTargetOut", branchTargetOut, pc);
    chk("dmemReq", {31'b0, dmemReq}, {31'b0, e_req});
    if (e_req) begin
      chk("dmemWe", {31'b0, dmemWe}, {31'b0, e_we});
      chk("dmemAddr", dmemAddr, e_addr);
      chk("dmemWData", dmemWData, e_wdata);
    end
    chk("timeoutOut", {31'b0, timeoutOut}, {31'b0, e_to});
    chk("haveInstrOut", {31'b0, haveInstrOut}, {31'b0, e_hv});
    chk("WBOut", {30'b0, WBOut}, {30'b0, e_wb});
    chk("readDataOut", readDataOut, e_rd);
    if (e_hv) begin
      chk("ALUOutOut", ALUOutOut, e_alu);
      chk("regFromMuxOut", {27'b0, regFromMuxOut}, {27'b0, e_rf});
    end
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misalignOut", {31'b0, misalignOut}, {31'b0, e_mis});
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic b, input logic r, input logic w,
                       input logic zz, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rr, input logic [1:0] ww);
    hv = h; br = b; mrd = r; mwr = w; z = zz; pc = p; alu = a; d2 = d; rf = rr; wb = ww;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 2'b00);
    ack = 0;
  endtask

  initial begin
    int stall_cnt, req_cnt, to_cnt;
    #1;
    chk("reset dmemReq", {31'b0, dmemReq}, 32'h0);
    chk("reset haveInstrOut", {31'b0, haveInstrOut}, 32'h0);
    chk("reset WBOut", {30'b0, WBOut}, 32'h0);
    step(); step();
    rst_n = 1;
    step();

    // ALU op: one-cycle pass-through, never stalls
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0000_0042, 32'h0, 5'd5, 2'b10);
    #1 chk("alu stall", {31'b0, stallOut}, 32'h0);
    step();
    chk("alu haveInstrOut", {31'b0, haveInstrOut}, 32'h1);
    chk("alu ALUOutOut", ALUOutOut, 32'h42);
    chk("alu regFromMuxOut", {27'b0, regFromMuxOut}, 32'd5);
    chk("alu readDataOut", readDataOut, 32'h0);
    chk("alu WBOut", {30'b0, WBOut}, 32'h2);

    // Branch resolution
    drive(1, 1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 5'd0, 2'b00);
    #1 chk("br taken", {31'b0, pcSrcOut}, 32'h1);
    chk("br target", branchTargetOut, 32'h40);
    z = 0;
    #1 chk("br zero0", {31'b0, pcSrcOut}, 32'h0);
    z = 1; hv = 0;
    #1 chk("br nohv", {31'b0, pcSrcOut}, 32'h0);
    step();
    idle(); step();

    // Load: stall covers request cycle plus three waiting cycles, ack in the fourth
    drive(1, 0, 1, 0, 0, 32'h0, 32'h100, 32'h0, 5'd7, 2'b11);
    rdata = 32'hDEAD_BEEF;
    stall_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      ack = (k == 4);
      #1 if (stallOut) stall_cnt++;
      if (k == 1) begin
        chk("ld dmemReq", {31'b0, dmemReq}, 32'h1);
        chk("ld dmemAddr", dmemAddr, 32'h100);
        chk("ld dmemWe", {31'b0, dmemWe}, 32'h0);
      end
      step();
    end
    idle();
    chk("ld stall cycles", stall_cnt, 32'd4);
    chk("ld readDataOut", readDataOut, 32'hDEAD_BEEF);
    chk("ld WBOut", {30'b0, WBOut}, 32'h3);
    chk("ld dmemReq off", {31'b0, dmemReq}, 32'h0);
    step();

    // Store with no ack: request held MAX_WAIT cycles, single timeout pulse
    drive(1, 0, 0, 1, 0, 32'h0, 32'h200, 32'hCAFE_F00D, 5'd0, 2'b00);
    req_cnt = 0; to_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 17) idle();
      #1;
      if (dmemReq && dmemWe && dmemWData == 32'hCAFE_F00D) req_cnt++;
      if (timeoutOut) to_cnt++;
      if (k == 17) begin
        chk("st to haveInstrOut", {31'b0, haveInstrOut}, 32'h0);
        chk("st to WBOut", {30'b0, WBOut}, 32'h0);
      end
      step();
    end
    chk("st req cycles", req_cnt, MAX_WAIT);
    chk("st timeout pulses", to_cnt, 32'd1);
    chk("st back idle stall", {31'b0, stallOut}, 32'h0);

    // Asynchronous reset in the middle of a wait
    drive(1, 0, 1, 0, 0, 32'h0, 32'h300, 32'h0, 5'd3, 2'b11);
    step(); step(); step();
    #2 rst_n = 0;
    #1;
    chk("rst dmemReq", {31'b0, dmemReq}, 32'h0);
    chk("rst stallOut", {31'b0, stallOut}, 32'h0);
    chk("rst haveInstrOut", {31'b0, haveInstrOut}, 32'h0);
    idle();
    step();
    #2 rst_n = 1;
    step();
    ack = 1; rdata = 32'h1234_5678;
    step();
    ack = 0;
    chk("stray ack dmemReq", {31'b0, dmemReq}, 32'h0);
    chk("stray ack readDataOut", readDataOut, 32'h0);
    chk("stray ack haveInstrOut", {31'b0, haveInstrOut}, 32'h0);
    step();

`ifdef MEM_MISALIGN_TRAP_EN
    drive(1, 0, 1, 0, 0, 32'h0, 32'h102, 32'h0, 5'd4, 2'b11);
    #1 chk("mis stall", {31'b0, stallOut}, 32'h0);
    step();
    idle();
    chk("mis pulse", {31'b0, misalignOut}, 32'h1);
    chk("mis dmemReq", {31'b0, dmemReq}, 32'h0);
    chk("mis haveInstrOut", {31'b0, haveInstrOut}, 32'h0);
    step();
    chk("mis pulse end", {31'b0, misalignOut}, 32'h0);
`endif

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
